wb_arbiter_2m: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter.
- Shares the single SoC Wishbone bus between the picorv32 Wishbone master (m0) and a second master (m1, debug/DMA).
- Round-robin grant, held for a whole bus cycle (cyc-locked), with zero-bubble handover.
- Per-transfer watchdog returns err to a master whose slave never acks.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_arb_watchdog.sv | 41 ++++
 rtl/wb_arbiter_2m.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared state/grant encodings and defaults for the 2-master
//             Wishbone arbiter and its watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'b00;
    localparam arb_state_t ST_G0   = 2'b01;
    localparam arb_state_t ST_G1   = 2'b10;
    localparam arb_state_t ST_ERR  = 2'b11;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TO_W_DEFAULT    = 8;

endpackage
`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb_watchdog
//  Purpose  : Saturating per-transfer wait counter; flags expiry when the
//             count reaches TIMEOUT-1 without a clear. TIMEOUT=0 disables it.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = TO_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_SAT  = {TO_W{1'b1}};
    localparam logic            WD_ON    = (TIMEOUT != 0);

    logic [TO_W-1:0] cnt_q;

    // A clear in the same cycle as the terminal count suppresses expiry.
    assign expire_o = WD_ON & en_i & ~clr_i & (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_2m
//  Purpose  : Round-robin, cyc-locked 2-master to 1-slave Wishbone classic
//             arbiter with zero-bubble handover and a per-transfer watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = TO_W_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_q,  last_d;
    logic       req0, req1;
    logic       wd_en, wd_clr, wd_expire;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    assign wd_en  = (state_q == ST_G0) | (state_q == ST_G1);
    assign wd_clr = s_ack_i | ~s_stb_o;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rstn_i),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie the master that was not served last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = ST_G0;
                end else if (req1) begin
                    state_d = ST_G1;
                end
            end
            ST_G0: begin
                if (wd_expire) begin
                    state_d = ST_ERR;
                    last_d  = 1'b0;
                end else if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = req1 ? ST_G1 : ST_IDLE;
                end
            end
            ST_G1: begin
                if (wd_expire) begin
                    state_d = ST_ERR;
                    last_d  = 1'b1;
                end else if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = req0 ? ST_G0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Bus mux is decoded from the registered state, so reset idles it at once.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = GNT_NONE;
        case (state_q)
            ST_G0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                gnt_o    = GNT_M0;
            end
            ST_G1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                gnt_o    = GNT_M1;
            end
            ST_ERR: begin
                m0_err_o = ~last_q;
                m1_err_o = last_q;
            end
            default: begin
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter_2m
//  Purpose  : Self-checking bench for wb_arbiter_2m (TIMEOUT=4): cycle vector
//             table for arbitration, plus scoreboarded master transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2m;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_adr = 32'hA0, m0_dat = '0, m1_adr = 32'hB0, m1_dat = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_we = 1'b0, m0_stb = 1'b0, m0_cyc = 1'b0;
    logic        m1_we = 1'b0, m1_stb = 1'b0, m1_cyc = 1'b0;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [31:0] s_dat_i = 32'h1234_5678;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    wb_arbiter_2m #(.TIMEOUT(4), .TO_W(8)) dut (
        .wb_clk_i (clk),      .wb_rstn_i (rst_n),
        .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat),  .m0_sel_i (m0_sel),
        .m0_we_i  (m0_we),    .m0_stb_i (m0_stb),  .m0_cyc_i (m0_cyc),
        .m0_dat_o (m0_rdat),  .m0_ack_o (m0_ack),  .m0_err_o (m0_err),
        .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat),  .m1_sel_i (m1_sel),
        .m1_we_i  (m1_we),    .m1_stb_i (m1_stb),  .m1_cyc_i (m1_cyc),
        .m1_dat_o (m1_rdat),  .m1_ack_o (m1_ack),  .m1_err_o (m1_err),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o), .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),   .s_stb_o  (s_stb_o), .s_cyc_o  (s_cyc_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i), .gnt_o    (gnt_o)
    );

    // Slave model: acks after a per-master number of wait cycles (-1 = never).
    logic tbl_mode = 1'b0, tbl_ack = 1'b0;
    int   dly0 = -1, dly1 = -1, wait_cnt = 0, cur_dly;
    logic slave_ack;
    assign cur_dly   = gnt_o[1] ? dly1 : dly0;
    assign slave_ack = s_cyc_o && s_stb_o && (cur_dly >= 0) && (wait_cnt == cur_dly);
    assign s_ack_i   = tbl_mode ? tbl_ack : slave_ack;

    always @(posedge clk) begin
        if (!(s_cyc_o && s_stb_o) || s_ack_i) wait_cnt <= 0;
        else                                  wait_cnt <= wait_cnt + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] rdata;
    } txn_t;
    txn_t sb_q[$];

    always @(negedge clk) begin
        txn_t t;
        if (!tbl_mode && rst_n && s_cyc_o && s_stb_o && s_ack_i) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: slave ack at adr 0x%0h with empty queue", s_adr_o);
            end else begin
                t = sb_q.pop_front();
                chk("sb_adr",  s_adr_o, t.adr);
                chk("sb_dat",  s_dat_o, t.dat);
                chk("sb_sel",  s_sel_o, t.sel);
                chk("sb_we",   s_we_o,  t.we);
                chk("sb_gnt",  gnt_o,   (t.m == 0) ? 2'b01 : 2'b10);
                chk("sb_acks", {m0_ack, m1_ack}, (t.m == 0) ? 2'b10 : 2'b01);
                if (!t.we) chk("sb_rdata", (t.m == 0) ? m0_rdat : m1_rdat, t.rdata);
            end
        end
    end

    task automatic drive_m(input int m, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input logic req);
        if (m == 0) begin
            m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_cyc = req; m0_stb = req;
        end else begin
            m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_cyc = req; m1_stb = req;
        end
    endtask

    // One single-beat transfer; ncyc counts cycles from the first granted cycle.
    task automatic xfer(input int m, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input int dly,
                        output int ncyc, output logic got_ack, output logic got_err,
                        output logic cyc_at_end);
        txn_t t;
        bit   started;
        if (m == 0) dly0 = dly; else dly1 = dly;
        if (dly >= 0) begin
            t.m = m; t.adr = adr; t.dat = dat; t.sel = sel; t.we = we; t.rdata = s_dat_i;
            sb_q.push_back(t);
        end
        @(posedge clk); #1;
        drive_m(m, adr, dat, sel, we, 1'b1);
        started = 0; ncyc = 0; got_ack = 0; got_err = 0; cyc_at_end = 0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!started && gnt_o == ((m == 0) ? 2'b01 : 2'b10)) started = 1;
            else if (started) ncyc++;
            if ((m == 0) ? (m0_ack || m0_err) : (m1_ack || m1_err)) begin
                got_ack    = (m == 0) ? m0_ack : m1_ack;
                got_err    = (m == 0) ? m0_err : m1_err;
                cyc_at_end = s_cyc_o;
                break;
            end
        end
        if (!(got_ack || got_err)) begin
            checks++; errors++;
            $display("FAIL xfer_m%0d_wait: no ack or err within 40 cycles", m);
        end
        @(posedge clk); #1;
        drive_m(m, adr, dat, sel, we, 1'b0);
    endtask

    // {c0 s0 c1 s1 | ack | gnt | s_cyc s_stb ack0 ack1}
    typedef struct packed {
        logic       c0, s0, c1, s1;
        logic       ack;
        logic [1:0] gnt;
        logic       scyc, sstb, ack0, ack1;
    } vec_t;
    vec_t vecs [19];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int   n0, n1;
        logic a0, e0, c0, a1, e1, c1;
        logic [31:0] exp_adr;

        vecs[0]  = 11'b1111_0_00_0000;  // tie seen in IDLE
        vecs[1]  = 11'b1111_1_01_1110;  // m0 wins first tie, beat 1 acked
        vecs[2]  = 11'b1111_0_01_1100;  // locked: m0 keeps cyc, m1 waits
        vecs[3]  = 11'b1111_1_01_1110;  // beat 2 acked
        vecs[4]  = 11'b0011_0_01_0000;  // m0 release cycle, s_cyc already 0
        vecs[5]  = 11'b0011_1_10_1101;  // zero-bubble handover to m1
        vecs[6]  = 11'b0000_0_10_0000;
        vecs[7]  = 11'b1111_0_00_0000;
        vecs[8]  = 11'b1111_1_01_1110;  // last was m1 -> m0
        vecs[9]  = 11'b0011_0_01_0000;
        vecs[10] = 11'b0011_1_10_1101;
        vecs[11] = 11'b0000_0_10_0000;
        vecs[12] = 11'b1100_0_00_0000;
        vecs[13] = 11'b1100_1_01_1110;
        vecs[14] = 11'b0000_0_01_0000;
        vecs[15] = 11'b1111_0_00_0000;
        vecs[16] = 11'b1111_0_10_1100;  // last was m0 -> m1
        vecs[17] = 11'b0000_0_10_0000;
        vecs[18] = 11'b0000_0_00_0000;

        // Reset dominates even with both masters requesting.
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {s_cyc_o, s_stb_o, gnt_o, m0_ack, m1_ack, m0_err, m1_err, s_adr_o, s_sel_o, s_we_o},
            '0);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        rst_n = 1;

        tbl_mode = 1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            m0_cyc = vecs[i].c0; m0_stb = vecs[i].s0;
            m1_cyc = vecs[i].c1; m1_stb = vecs[i].s1;
            tbl_ack = vecs[i].ack;
            @(negedge clk);
            exp_adr = (vecs[i].gnt == 2'b01) ? 32'hA0 : (vecs[i].gnt == 2'b10) ? 32'hB0 : 32'h0;
            chk($sformatf("vec%0d", i),
                {gnt_o, s_cyc_o, s_stb_o, m0_ack, m1_ack, m0_err, m1_err, s_adr_o},
                {vecs[i].gnt, vecs[i].scyc, vecs[i].sstb, vecs[i].ack0, vecs[i].ack1, 2'b00, exp_adr});
        end
        tbl_ack = 0;
        tbl_mode = 0;

        // Reset mid-transfer: make m0 the last-served master, then grant it again.
        dly0 = -1;
        @(posedge clk); #1; m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #1;
        @(negedge clk); chk("rst_pre_gnt", gnt_o, 2'b01);
        @(posedge clk); #1; m0_cyc = 0; m0_stb = 0;
        @(posedge clk); #1; m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #2;
        chk("rst_pre_active", {s_cyc_o, s_stb_o, gnt_o}, 4'b1101);
        rst_n = 0;
        #1;
        chk("rst_async_idle", {s_cyc_o, s_stb_o, gnt_o}, 4'b0000);
        m1_cyc = 1; m1_stb = 1;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk); chk("rst_tie_m0", gnt_o, 2'b01);
        @(posedge clk); #1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        repeat (2) @(posedge clk);

        // Data path: m1 write then read.
        xfer(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 2, n1, a1, e1, c1);
        chk("wr_ack_err", {a1, e1}, 2'b10);
        chk("wr_latency", n1, 2);
        @(negedge clk); chk("wr_ack_pulse", {m0_ack, m1_ack}, 2'b00);
        xfer(1, 32'h1000_0014, 32'h0, 4'hF, 1'b0, 0, n1, a1, e1, c1);
        chk("rd_ack_err", {a1, e1}, 2'b10);
        chk("rd_common_dat", m0_rdat, 32'h1234_5678);

        // Timeout on m0 while m1 queues behind it.
        fork
            begin
                xfer(0, 32'h2000_0000, 32'h0, 4'hF, 1'b0, -1, n0, a0, e0, c0);
            end
            begin
                @(posedge clk);
                xfer(1, 32'h3000_0000, 32'hCAFE_F00D, 4'h3, 1'b1, 1, n1, a1, e1, c1);
            end
        join
        chk("to_err", {a0, e0}, 2'b01);
        chk("to_cycle", n0, 4);
        chk("to_s_cyc", c0, 1'b0);
        chk("to_m1_served", {a1, e1}, 2'b10);

        // Ack on the expiry cycle wins.
        xfer(0, 32'h4000_0000, 32'h5555_AAAA, 4'hC, 1'b1, 3, n0, a0, e0, c0);
        chk("exp_ack_err", {a0, e0}, 2'b10);
        chk("exp_latency", n0, 3);
        @(negedge clk); chk("exp_no_err", {m0_err, m1_err}, 2'b00);

        repeat (2) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
